// File: rtl/iic_pkg.sv
// Shared I2C definitions: target FSM states, bus bit constants and byte width.
package iic_pkg;

    localparam int unsigned IIC_BYTE_W = 8;

    localparam logic IIC_ACK     = 1'b0;
    localparam logic IIC_NACK    = 1'b1;
    localparam logic IIC_RW_READ = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrite,
        StWriteAck,
        StRead,
        StMack
    } iic_state_e;

endpackage

// File: rtl/iic_line_sync.sv
// One bus line: synchroniser, optional 3-sample glitch filter, rise/fall detect.
// Filter is built when IIC_TARGET_GLITCH_FILTER_EN is defined.
module iic_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   level_q;

    // Bus lines idle high, so reset the chain to 1 to avoid a false edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef IIC_TARGET_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], synced};
            if (synced == hist_q[0] && synced == hist_q[1]) begin
                filt_q <= synced;
            end
        end
    end

    assign level = filt_q;
`else
    assign level = synced;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/iic_target.sv
// I2C target endpoint: fixed 7-bit address, byte receive to rx_data and byte
// transmit from tx_data. Optional IIC_TARGET_GLITCH_FILTER_EN filters SCL/SDA.
module iic_target
    import iic_pkg::*;
#(
    parameter logic [6:0]  ADDR        = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [IIC_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [IIC_BYTE_W-1:0] tx_data,
    output logic                  tx_req,
    output logic                  busy,
    output logic                  rw
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start, stop;

    iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .line    (scl),
        .level   (scl_level),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .line    (sda),
        .level   (sda_level),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    assign start = sda_fall & scl_level;
    assign stop  = sda_rise & scl_level;

    iic_state_e            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [IIC_BYTE_W-2:0] shreg_q, shreg_d;
    logic [IIC_BYTE_W-1:0] tx_shift_q, tx_shift_d;
    logic [IIC_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  phase_q, phase_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_req_q, tx_req_d;
    logic                  busy_q, busy_d;
    logic                  rw_q, rw_d;
    logic [IIC_BYTE_W-1:0] shifted;
    logic                  load_tx;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            phase_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            phase_q    <= phase_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
        end
    end

    assign shifted = {shreg_q, sda_level};

    // phase_q: in the ACK states, set once SDA is pulled low; in MACK, set on controller ACK.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        rw_d       = rw_q;
        load_tx    = 1'b0;

        if (stop) begin
            state_d  = StIdle;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise) begin
                        shreg_d   = shifted[IIC_BYTE_W-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shifted[7:1] == ADDR) begin
                                rw_d    = shifted[0];
                                busy_d  = 1'b1;
                                phase_d = 1'b0;
                                state_d = StAddrAck;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = StIdle;
                            end
                        end
                    end
                end
                StAddrAck, StWriteAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == StAddrAck && rw_q == IIC_RW_READ) begin
                                load_tx = 1'b1;
                            end else begin
                                state_d = StWrite;
                            end
                        end
                    end
                end
                StWrite: begin
                    if (scl_rise) begin
                        shreg_d   = shifted[IIC_BYTE_W-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = shifted;
                            rx_valid_d = 1'b1;
                            phase_d    = 1'b0;
                            state_d    = StWriteAck;
                        end
                    end
                end
                StRead: begin
                    // bit_cnt counts rises; it is back to 0 on the fall after bit 0.
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = StMack;
                        end else begin
                            sda_oe_d   = ~tx_shift_q[IIC_BYTE_W-1];
                            tx_shift_d = {tx_shift_q[IIC_BYTE_W-2:0], 1'b0};
                        end
                    end
                end
                StMack: begin
                    if (scl_rise) begin
                        if (sda_level == IIC_ACK) begin
                            phase_d = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end
                    end else if (scl_fall && phase_q) begin
                        load_tx = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (load_tx) begin
            tx_req_d   = 1'b1;
            sda_oe_d   = ~tx_data[IIC_BYTE_W-1];
            tx_shift_d = {tx_data[IIC_BYTE_W-2:0], 1'b0};
            bit_cnt_d  = '0;
            state_d    = StRead;
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;
    assign rw       = rw_q;

endmodule

// File: tb/tb_iic_target.sv
// Directed bench for iic_target: a behavioural bus controller drives SCL/SDA.
module tb_iic_target;
    import iic_pkg::*;

    localparam int Q = 50;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, busy, rw;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clock = ~clock;

    iic_target #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .scl      (scl),
        .sda      (sda),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .rw       (rw)
    );

    int n_checks = 0;
    int n_errors = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int tgt_low_cnt = 0;
    int addr_cyc = 0;

    always @(posedge clock) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (tx_req) tx_cnt <= tx_cnt + 1;
        if (sda === 1'b0 && !m_sda_low) tgt_low_cnt <= tgt_low_cnt + 1;
        if (dut.state_q == StAddr) addr_cyc <= addr_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic xfer_bit(input logic b, output logic s);
        #Q; m_sda_low = ~b;
        #Q; scl = 1'b1;
        #Q; s = (sda !== 1'b0);
        #Q; scl = 1'b0;
    endtask

    task automatic bus_start();
        #Q; m_sda_low = 1'b0;
        #Q; scl = 1'b1;
        #Q; m_sda_low = 1'b1;
        #Q; scl = 1'b0;
    endtask

    task automatic bus_stop();
        #Q; m_sda_low = 1'b1;
        #Q; scl = 1'b1;
        #Q; m_sda_low = 1'b0;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], s);
        xfer_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic m_ack, input logic [7:0] next_tx, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, s);
            d[i] = s;
        end
        tx_data = next_tx;
        xfer_bit(m_ack, s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         rx0, tx0, low0, addr0;

        repeat (4) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_tx_req", 32'(tx_req), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rw", 32'(rw), 32'h0);
        check("rst_sda", 32'(sda !== 1'b0), 32'h1);

        // Write 0xA5 to 0x50
        rx0 = rx_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", 32'(ack), 32'h0);
        check("wr_busy", 32'(busy), 32'h1);
        check("wr_rw", 32'(rw), 32'h0);
        write_byte(8'hA5, ack);
        check("wr_data_ack", 32'(ack), 32'h0);
        check("wr_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        check("wr_rx_data", 32'(rx_data), 32'hA5);
        bus_stop();
        check("wr_busy_stop", 32'(busy), 32'h0);

        // Address 0x51: ignored
        rx0 = rx_cnt;
        low0 = tgt_low_cnt;
        bus_start();
        write_byte(8'hA2, ack);
        check("miss_addr_nack", 32'(ack), 32'h1);
        check("miss_busy", 32'(busy), 32'h0);
        write_byte(8'h11, ack);
        check("miss_data_nack", 32'(ack), 32'h1);
        bus_stop();
        check("miss_no_drive", 32'(tgt_low_cnt - low0), 32'd0);
        check("miss_no_rx", 32'(rx_cnt - rx0), 32'd0);

        // Read two bytes, ACK then NACK
        tx0 = tx_cnt;
        tx_data = 8'h3C;
        bus_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", 32'(ack), 32'h0);
        check("rd_rw", 32'(rw), 32'h1);
        check("rd_busy", 32'(busy), 32'h1);
        read_byte(1'b0, 8'hC3, d);
        check("rd_byte0", 32'(d), 32'h3C);
        read_byte(1'b1, 8'h00, d);
        check("rd_byte1", 32'(d), 32'hC3);
        check("rd_tx_req", 32'(tx_cnt - tx0), 32'd2);
        check("rd_busy_nack", 32'(busy), 32'h0);
        check("rd_state_idle", 32'(dut.state_q), 32'(StIdle));
        bus_stop();

        // Repeated START mid write byte, then read
        rx0 = rx_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check("rs_wr_ack", 32'(ack), 32'h0);
        xfer_bit(1'b1, ack);
        xfer_bit(1'b0, ack);
        xfer_bit(1'b1, ack);
        xfer_bit(1'b0, ack);
        tx_data = 8'h5A;
        bus_start();
        write_byte(8'hA1, ack);
        check("rs_rd_ack", 32'(ack), 32'h0);
        check("rs_rw", 32'(rw), 32'h1);
        read_byte(1'b1, 8'h00, d);
        check("rs_byte", 32'(d), 32'h5A);
        check("rs_no_rx", 32'(rx_cnt - rx0), 32'd0);
        bus_stop();

        // Reset while target drives a 0 bit
        tx_data = 8'h00;
        bus_start();
        write_byte(8'hA1, ack);
        #Q;
        check("rst_mid_drv0", 32'(sda !== 1'b0), 32'h0);
        @(negedge clock) reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("rst_mid_sda", 32'(sda !== 1'b0), 32'h1);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_rw", 32'(rw), 32'h0);
        check("rst_mid_rx_data", 32'(rx_data), 32'h0);
        check("rst_mid_tx_req", 32'(tx_req), 32'h0);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'h0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        bus_stop();

        // 2-clock SDA low pulse while SCL is high
        addr0 = addr_cyc;
        #Q;
        @(negedge clock) m_sda_low = 1'b1;
        repeat (2) @(negedge clock);
        m_sda_low = 1'b0;
        repeat (12) @(negedge clock);
`ifdef IIC_TARGET_GLITCH_FILTER_EN
        check("glitch_no_start", 32'(addr_cyc - addr0), 32'd0);
`else
        check("glitch_start_seen", 32'(addr_cyc != addr0), 32'h1);
`endif
        check("glitch_state_idle", 32'(dut.state_q), 32'(StIdle));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
